// File: rtl/processor_pkg.sv
// Shared definitions for the processor interrupt controller.
//   irq_state_e     : controller FSM states (IDLE / REQ / SERVICE)
//   Cfg*            : cfg_addr register map
//   Status*         : bit positions inside the STATUS register
package processor_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StReq     = 2'd1,
      StService = 2'd2
   } irq_state_e;

   localparam logic [1:0] CfgMask    = 2'd0;
   localparam logic [1:0] CfgEdge    = 2'd1;
   localparam logic [1:0] CfgPending = 2'd2;
   localparam logic [1:0] CfgStatus  = 2'd3;

   localparam int unsigned StatusStateLsb = 0;
   localparam int unsigned StatusInSvcBit = 2;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt channel front end: SyncStages-deep synchroniser followed by a
// single register used both as the delayed level and for rising-edge detect.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   irq_i         : raw asynchronous source
//   level_o       : synchronised level, aligned with rise_o
//   rise_o        : one-cycle pulse per rising edge
module irq_sync_edge #(
   parameter int unsigned SyncStages = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic irq_i,
   output logic level_o,
   output logic rise_o
);

   logic [SyncStages-1:0] sync_q, sync_d;
   logic                  prev_q, prev_d;
   logic                  rise_q, rise_d;

   always_comb begin
      sync_d = {sync_q[SyncStages-2:0], irq_i};
      prev_d = sync_q[SyncStages-1];
      rise_d = sync_q[SyncStages-1] & ~prev_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
      end
   end

   assign level_o = prev_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/processor_irq_ctrl.sv
// Multi-channel interrupt controller feeding the control unit with one
// prioritised request (channel 0 highest) over a req/ack/done handshake.
// Optional nesting (preemption + in-service stack) with PROCESSOR_IRQ_NEST_EN.
//   clock, reset        : clock, asynchronous active-low reset
//   irq_in              : raw interrupt sources
//   cfg_we/addr/wdata   : register write port (MASK, EDGE, PENDING W1C)
//   cfg_rdata           : combinational register read (STATUS = {in_svc, state})
//   irq_req, irq_id     : request and channel of current request/service
//   irq_ack, irq_done   : handler entry / return from interrupt
//   LED                 : high while an interrupt is in service
module processor_irq_ctrl
   import processor_pkg::*;
#(
   parameter int unsigned NUM_IRQ     = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned NEST_DEPTH  = 4,
   localparam int unsigned ID_W       = $clog2(NUM_IRQ)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_addr,
   input  logic [NUM_IRQ-1:0] cfg_wdata,
   output logic [NUM_IRQ-1:0] cfg_rdata,
   output logic               irq_req,
   output logic [ID_W-1:0]    irq_id,
   input  logic               irq_ack,
   input  logic               irq_done,
   output logic               LED
);

   // Range guard: an out-of-range configuration shows up as g_bad_params.
   if (NUM_IRQ < 2 || NUM_IRQ > 32 || SYNC_STAGES < 2 || NEST_DEPTH < 1) begin : g_bad_params
   end

   logic [NUM_IRQ-1:0] level, rise;

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
      irq_sync_edge #(
         .SyncStages (SYNC_STAGES)
      ) u_sync (
         .clk_i   (clock),
         .rst_ni  (reset),
         .irq_i   (irq_in[g]),
         .level_o (level[g]),
         .rise_o  (rise[g])
      );
   end

   logic [NUM_IRQ-1:0] mask_q, mask_d, edge_q, edge_d, pend_q, pend_d;
   logic [NUM_IRQ-1:0] active, w1c, ack_clr;
   logic [ID_W-1:0]    winner, id_q, id_d;
   irq_state_e         state_q, state_d;
   logic               in_svc;

`ifdef PROCESSOR_IRQ_NEST_EN
   localparam int unsigned SP_W  = $clog2(NEST_DEPTH + 1);
   localparam int unsigned IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

   logic [ID_W-1:0] stack_q [NEST_DEPTH];
   logic [ID_W-1:0] stack_d [NEST_DEPTH];
   logic [SP_W-1:0] sp_q, sp_d;
   logic [ID_W-1:0] svc_id_q, svc_id_d;
   logic            pre_q, pre_d;     // REQ entered by preempting svc_id_q
`endif

   assign active = pend_q & mask_q;

   // Lowest set index wins.
   always_comb begin
      winner = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (active[i]) winner = ID_W'(i);
      end
   end

   always_comb begin
      mask_d = mask_q;
      edge_d = edge_q;
      w1c    = '0;
      if (cfg_we) begin
         case (cfg_addr)
            CfgMask:    mask_d = cfg_wdata;
            CfgEdge:    edge_d = cfg_wdata;
            CfgPending: w1c    = cfg_wdata;
            default:    ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      ack_clr = '0;
`ifdef PROCESSOR_IRQ_NEST_EN
      stack_d  = stack_q;
      sp_d     = sp_q;
      svc_id_d = svc_id_q;
      pre_d    = pre_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (|active) begin
               state_d = StReq;
               id_d    = winner;
            end
         end
         StReq: begin
            if (irq_ack) begin
               state_d       = StService;
               ack_clr[id_q] = 1'b1;
`ifdef PROCESSOR_IRQ_NEST_EN
               if (pre_q) begin
                  stack_d[IDX_W'(sp_q)] = svc_id_q;
                  sp_d                  = sp_q + 1'b1;
                  pre_d                 = 1'b0;
               end
`endif
            end else if (!active[id_q]) begin
               state_d = StIdle;
`ifdef PROCESSOR_IRQ_NEST_EN
               // Withdrawn preemption falls back to the handler it interrupted.
               if (pre_q) begin
                  state_d = StService;
                  id_d    = svc_id_q;
                  pre_d   = 1'b0;
               end
`endif
            end
         end
         StService: begin
            if (irq_done) begin
               state_d = StIdle;
`ifdef PROCESSOR_IRQ_NEST_EN
               if (sp_q != '0) begin
                  state_d = StService;
                  id_d    = stack_q[IDX_W'(sp_q - 1'b1)];
                  sp_d    = sp_q - 1'b1;
               end
`endif
            end
`ifdef PROCESSOR_IRQ_NEST_EN
            else if ((|active) && (winner < id_q) && (sp_q != SP_W'(NEST_DEPTH))) begin
               state_d  = StReq;
               id_d     = winner;
               svc_id_d = id_q;
               pre_d    = 1'b1;
            end
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   // Edge channels: set beats any same-cycle clear. Level channels track the input.
   assign pend_d = (edge_q & ((pend_q & ~w1c & ~ack_clr) | rise)) | (~edge_q & level);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mask_q  <= '0;
         edge_q  <= '0;
         pend_q  <= '0;
         state_q <= StIdle;
         id_q    <= '0;
      end else begin
         mask_q  <= mask_d;
         edge_q  <= edge_d;
         pend_q  <= pend_d;
         state_q <= state_d;
         id_q    <= id_d;
      end
   end

`ifdef PROCESSOR_IRQ_NEST_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(NEST_DEPTH); i++) stack_q[i] <= '0;
         sp_q     <= '0;
         svc_id_q <= '0;
         pre_q    <= 1'b0;
      end else begin
         stack_q  <= stack_d;
         sp_q     <= sp_d;
         svc_id_q <= svc_id_d;
         pre_q    <= pre_d;
      end
   end

   assign in_svc = (state_q == StService) || (sp_q != '0) || pre_q;
`else
   assign in_svc = (state_q == StService);
`endif

   always_comb begin
      logic [31:0] status;
      status                            = '0;
      status[StatusStateLsb +: 2]       = state_q;
      status[StatusInSvcBit]            = in_svc;
      cfg_rdata                         = '0;
      case (cfg_addr)
         CfgMask:    cfg_rdata = mask_q;
         CfgEdge:    cfg_rdata = edge_q;
         CfgPending: cfg_rdata = pend_q;
         default:    cfg_rdata = status[NUM_IRQ-1:0];
      endcase
   end

   assign irq_req = (state_q == StReq);
   assign irq_id  = id_q;
   assign LED     = in_svc;

endmodule
